// File: rtl/nn_layer_seq.sv
// nn_layer_seq: time-multiplexed FP layer engine (bias + sum w*x per neuron, then activation) over MAC/activation handshakes
// Optional NN_LAYER_ZERO_SKIP_EN: elements whose captured x is +/-0 take one cycle without a MAC request.
module nn_layer_seq #(
  parameter int exp_width = 8,
  parameter int mant_width = 24,
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter int ACT_MODE = 0,
  localparam int DW = exp_width + mant_width
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [2:0]               round_mode,
  input  logic                     start,
  input  logic [N_IN*DW-1:0]       in_vec,
  input  logic [N_OUT*N_IN*DW-1:0] weights,
  input  logic [N_OUT*DW-1:0]      biases,
  output logic                     mac_req,
  output logic [DW-1:0]            mac_a,
  output logic [DW-1:0]            mac_b,
  output logic [DW-1:0]            mac_c,
  output logic [2:0]               mac_round_mode,
  input  logic                     mac_ack,
  input  logic [DW-1:0]            mac_result,
  output logic                     act_req,
  output logic [DW-1:0]            act_x,
  input  logic                     act_ack,
  input  logic [DW-1:0]            act_y,
  output logic [N_OUT*DW-1:0]      out_vec,
  output logic                     ready,
  output logic                     done
);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} st_t;
  st_t st;
  logic [N_IN*DW-1:0] xr;
  logic [N_OUT*N_IN*DW-1:0] wr;
  logic [N_OUT*DW-1:0] br, res;
  logic [DW-1:0] acc, xi, nacc, fin;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [2:0] rm;
  logic skip, step, adv, last_i, last_j;
  always_comb begin
    xi = xr[i*DW +: DW];
`ifdef NN_LAYER_ZERO_SKIP_EN
    skip = st == MAC && xi[DW-2:0] == '0;
`else
    skip = 1'b0;
`endif
    mac_req = st == MAC && !skip;
    mac_a = wr[(j*N_IN+i)*DW +: DW];
    mac_b = xi;
    mac_c = acc;
    mac_round_mode = rm;
    act_req = ACT_MODE == 0 && st == ACT;
    act_x = acc;
    ready = st == IDLE;
    step = skip || (mac_req && mac_ack);
    nacc = skip ? acc : mac_result;
    fin = ACT_MODE == 2 && nacc[DW-1] ? '0 : nacc;
    last_i = i == IW'(N_IN-1);
    last_j = j == JW'(N_OUT-1);
    adv = (st == MAC && step && last_i && ACT_MODE != 0) || (act_req && act_ack);
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      st <= IDLE;
      xr <= '0;
      wr <= '0;
      br <= '0;
      rm <= '0;
      acc <= '0;
      i <= '0;
      j <= '0;
      res <= '0;
      out_vec <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          xr <= in_vec;
          wr <= weights;
          br <= biases;
          rm <= round_mode;
          acc <= biases[DW-1:0];
          i <= '0;
          j <= '0;
          st <= MAC;
        end
        MAC: if (step) begin
          acc <= nacc;
          if (!last_i) i <= i + 1'b1;
          else if (ACT_MODE == 0) st <= ACT;
        end
        DONE: begin
          out_vec <= res;
          done <= 1'b1;
          st <= IDLE;
        end
        default: ;
      endcase
      if (adv) begin
        res[j*DW +: DW] <= st == ACT ? act_y : fin;
        if (last_j) st <= DONE;
        else begin
          j <= j + 1'b1;
          i <= '0;
          acc <= br[(j+1)*DW +: DW];
          st <= MAC;
        end
      end
    end
  end
endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq: directed checks of nn_layer_seq in ACT_MODE 0/1/2 against FP MAC and activation models
module tb_nn_layer_seq;
  localparam int DW = 32;
  logic clk = 0;
  logic rst_l = 1;
  logic [2:0] rm;
  logic [63:0] in_vec, biases;
  logic [127:0] weights;
  logic start [3];
  logic mac_req [3], mac_ack [3], act_req [3], act_ack [3], ready [3], done [3];
  logic [DW-1:0] mac_a [3], mac_b [3], mac_c [3], mac_res [3], act_x [3], act_y [3];
  logic [2:0] mrm [3];
  logic [63:0] out_vec [3];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic real f2d(input logic [31:0] f);
    if (f[30:0] == 0) return $bitstoreal({f[31], 63'd0});
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] f2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  nn_layer_seq #(.ACT_MODE(0)) u0 (.clk(clk), .rst_l(rst_l), .round_mode(rm), .start(start[0]), .in_vec(in_vec),
    .weights(weights), .biases(biases), .mac_req(mac_req[0]), .mac_a(mac_a[0]), .mac_b(mac_b[0]), .mac_c(mac_c[0]),
    .mac_round_mode(mrm[0]), .mac_ack(mac_ack[0]), .mac_result(mac_res[0]), .act_req(act_req[0]), .act_x(act_x[0]),
    .act_ack(act_ack[0]), .act_y(act_y[0]), .out_vec(out_vec[0]), .ready(ready[0]), .done(done[0]));
  nn_layer_seq #(.ACT_MODE(1)) u1 (.clk(clk), .rst_l(rst_l), .round_mode(rm), .start(start[1]), .in_vec(in_vec),
    .weights(weights), .biases(biases), .mac_req(mac_req[1]), .mac_a(mac_a[1]), .mac_b(mac_b[1]), .mac_c(mac_c[1]),
    .mac_round_mode(mrm[1]), .mac_ack(mac_ack[1]), .mac_result(mac_res[1]), .act_req(act_req[1]), .act_x(act_x[1]),
    .act_ack(act_ack[1]), .act_y(act_y[1]), .out_vec(out_vec[1]), .ready(ready[1]), .done(done[1]));
  nn_layer_seq #(.ACT_MODE(2)) u2 (.clk(clk), .rst_l(rst_l), .round_mode(rm), .start(start[2]), .in_vec(in_vec),
    .weights(weights), .biases(biases), .mac_req(mac_req[2]), .mac_a(mac_a[2]), .mac_b(mac_b[2]), .mac_c(mac_c[2]),
    .mac_round_mode(mrm[2]), .mac_ack(mac_ack[2]), .mac_result(mac_res[2]), .act_req(act_req[2]), .act_x(act_x[2]),
    .act_ack(act_ack[2]), .act_y(act_y[2]), .out_vec(out_vec[2]), .ready(ready[2]), .done(done[2]));
  for (genvar g = 0; g < 3; g++) begin : m
    localparam int MD = g == 0 ? 3 : 0;
    int mc = 0, ac = 0;
    assign mac_ack[g] = mac_req[g] && mc == MD;
    assign mac_res[g] = f2s(f2d(mac_a[g]) * f2d(mac_b[g]) + f2d(mac_c[g]));
    assign act_ack[g] = act_req[g] && ac == 2;
    assign act_y[g] = act_x[g] + 32'h3f800000;
    always @(posedge clk) begin
      mc <= mac_req[g] && !mac_ack[g] ? mc + 1 : 0;
      ac <= act_req[g] && !act_ack[g] ? ac + 1 : 0;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic stim_a;
    in_vec = {32'h0, 32'h3f800000};
    weights = {32'hc0800000, 32'hc0800000, 32'h40800000, 32'h40800000};
    biases = {32'h40c00000, 32'hc0000000};
  endtask
  task automatic run(input int g, input int poke, output int lat, output int reqs, output int bad);
    logic pr, pk, qr, qk;
    logic [31:0] pa, pb, pc, px;
    lat = 0;
    reqs = 0;
    bad = 0;
    start[g] = 1;
    @(posedge clk); #1;
    start[g] = 0;
    while (!done[g] && lat < 200) begin
      if (lat == poke) begin
        start[g] = 1;
        in_vec = 64'h40000000_40000000;
        rm = 3'd5;
      end else start[g] = 0;
      reqs += int'(mac_req[g]);
      pr = mac_req[g]; pk = mac_ack[g]; pa = mac_a[g]; pb = mac_b[g]; pc = mac_c[g];
      qr = act_req[g]; qk = act_ack[g]; px = act_x[g];
      @(posedge clk); #1;
      lat++;
      if (pr && !pk && (!mac_req[g] || mac_a[g] !== pa || mac_b[g] !== pb || mac_c[g] !== pc)) bad++;
      if (qr && !qk && (!act_req[g] || act_x[g] !== px)) bad++;
    end
    start[g] = 0;
  endtask
  initial begin
    int lat, reqs, bad, extra;
    for (int k = 0; k < 3; k++) start[k] = 0;
    rm = 3'd2;
    stim_a();
    #2 rst_l = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 64'(ready[k]), 64'd1);
      chk("rst_done", 64'(done[k]), 64'd0);
      chk("rst_mac_req", 64'(mac_req[k]), 64'd0);
      chk("rst_act_req", 64'(act_req[k]), 64'd0);
      chk("rst_out_vec", out_vec[k], 64'd0);
      chk("rst_mac_a", 64'(mac_a[k]), 64'd0);
    end
    rst_l = 1;
    @(posedge clk); #1;
    run(1, -1, lat, reqs, bad);
    chk("id_out", out_vec[1], 64'h40000000_40000000);
    chk("id_lat", 64'(lat), 64'd5);
`ifdef NN_LAYER_ZERO_SKIP_EN
    chk("id_reqs", 64'(reqs), 64'd2);
`else
    chk("id_reqs", 64'(reqs), 64'd4);
`endif
    chk("id_rm", 64'(mrm[1]), 64'd2);
    chk("id_ready", 64'(ready[1]), 64'd1);
    @(posedge clk); #1;
    chk("id_done_pulse", 64'(done[1]), 64'd0);
    run(2, -1, lat, reqs, bad);
    chk("relu_pos_out", out_vec[2], 64'h40000000_40000000);
    in_vec = 64'h0;
    biases = {32'h80000000, 32'hc0c00000};
    run(2, -1, lat, reqs, bad);
    chk("relu_neg_out", out_vec[2], 64'h0);
    chk("relu_lat", 64'(lat), 64'd5);
    stim_a();
    rm = 3'd2;
    run(0, 5, lat, reqs, bad);
    chk("ext_out", out_vec[0], 64'h7f800000_7f800000);
`ifdef NN_LAYER_ZERO_SKIP_EN
    chk("ext_lat", 64'(lat), 64'd17);
`else
    chk("ext_lat", 64'(lat), 64'd23);
`endif
    chk("ext_stable", 64'(bad), 64'd0);
    chk("ext_rm", 64'(mrm[0]), 64'd2);
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      extra += int'(done[0]);
    end
    chk("ext_no_extra_done", 64'(extra), 64'd0);
    stim_a();
    start[1] = 1;
    @(posedge clk); #1;
    start[1] = 0;
    @(posedge clk); #1;
    rst_l = 0;
    #1;
    chk("mid_rst_mac_req", 64'(mac_req[1]), 64'd0);
    chk("mid_rst_ready", 64'(ready[1]), 64'd1);
    chk("mid_rst_out_vec", out_vec[1], 64'd0);
    @(posedge clk); #1;
    rst_l = 1;
    @(posedge clk); #1;
    run(1, -1, lat, reqs, bad);
    chk("post_rst_out", out_vec[1], 64'h40000000_40000000);
    chk("post_rst_lat", 64'(lat), 64'd5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
